// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, NOP code, opcode fields and fetch FSM states
package pipe_pkg;
   localparam int PC_W = 6;
   localparam logic [7:0] NOP_CODE = 8'h00;
   localparam int OP_HI = 7;
   localparam int OP_LO = 6;
   localparam int TGT_HI = 5;
   localparam int TGT_LO = 0;
   localparam logic [1:0] OP_JMP = 2'b11;
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
endpackage

// File: rtl/instr_mem.sv
// instr_mem: flop array, async active-low clear, sync write, async read
module instr_mem #(
   parameter int AW = 6,
   parameter logic [7:0] CLR = 8'h00
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);
   logic [7:0] mem [2**AW];
   always_ff @(posedge clk or negedge rst)
      if (!rst) mem <= '{default: CLR};
      else if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: IF stage - program load, PC sequencing, stall/redirect, NOP squash
module instr_fetch #(
   parameter int PC_W = pipe_pkg::PC_W,
   parameter logic [7:0] NOP_CODE = pipe_pkg::NOP_CODE
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_en,
   input  logic [PC_W-1:0] load_addr,
   input  logic [7:0]      load_data,
   input  logic            start,
   input  logic            stall,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   output logic [7:0]      instruc_code,
   output logic [PC_W-1:0] pc,
   output logic            running
);
   import pipe_pkg::*;
   state_t state, state_nx;
   logic [7:0] rdata;
   logic we;
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      we = 1'b0;
      if (state != RUN) begin
         we = load_en;
         state_nx = start ? RUN : load_en ? LOAD : state;
      end
   end
   // pc stays 0 until RUN so execution always begins at address 0
   always_ff @(posedge clk or negedge rst)
      if (!rst) pc <= '0;
      else if (state != RUN) pc <= '0;
      else if (redirect) pc <= redirect_pc;
      else if (!stall) pc <= pc + 1'b1;
   instr_mem #(.AW(PC_W), .CLR(NOP_CODE)) u_mem (
      .clk(clk), .rst(rst), .we(we), .waddr(load_addr), .wdata(load_data),
      .raddr(pc), .rdata(rdata)
   );
   // redirect squashes the wrong-path fetch so IF/ID latches a bubble
   assign instruc_code = (state == RUN && !redirect) ? rdata : NOP_CODE;
   assign running = (state == RUN);
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vectors, expected outputs queued and checked by a monitor
module tb_instr_fetch;
   logic clk = 0, rst = 0;
   logic load_en = 0, start = 0, stall = 0, redirect = 0;
   logic [5:0] load_addr = 0, redirect_pc = 0, pc;
   logic [7:0] load_data = 0, instruc_code;
   logic running;
   int errors = 0, checks = 0;
   typedef struct {string n; logic [7:0] code; logic [5:0] pc; logic run;} exp_t;
   exp_t sb[$];

   instr_fetch dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .start(start), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .instruc_code(instruc_code), .pc(pc), .running(running)
   );

   always #5 clk = ~clk;

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   // drive one cycle of inputs just after the rising edge and queue that cycle's outputs
   task automatic step(string n, logic le, logic [5:0] la, logic [7:0] ld, logic st,
                       logic sl, logic rd, logic [5:0] rp,
                       logic [7:0] ec, logic [5:0] ep, logic er);
      exp_t e;
      @(posedge clk);
      #1;
      load_en = le; load_addr = la; load_data = ld; start = st;
      stall = sl; redirect = rd; redirect_pc = rp;
      e.n = n; e.code = ec; e.pc = ep; e.run = er;
      sb.push_back(e);
   endtask

   always @(negedge clk)
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         chk({e.n, ".code"}, 32'(instruc_code), 32'(e.code));
         chk({e.n, ".pc"}, 32'(pc), 32'(e.pc));
         chk({e.n, ".run"}, 32'(running), 32'(e.run));
      end

   initial begin
      #3;
      chk("rst.code", 32'(instruc_code), 32'h00);
      chk("rst.pc", 32'(pc), 0);
      chk("rst.run", 32'(running), 0);
      @(posedge clk); #1 rst = 1;
      //          name    le la   ld     st sl rd rp  code   pc run
      step("ld0",  1, 0, 8'h41, 0, 0, 0, 0, 8'h00, 0, 0);
      step("ld1a", 1, 1, 8'h99, 0, 0, 0, 0, 8'h00, 0, 0);
      step("ld1b", 1, 1, 8'h52, 0, 0, 0, 0, 8'h00, 0, 0);
      step("ld2",  1, 2, 8'h63, 0, 0, 0, 0, 8'h00, 0, 0);
      step("ld3",  1, 3, 8'h74, 0, 0, 0, 0, 8'h00, 0, 0);
      step("start",0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0);
      step("run0", 0, 0, 8'h00, 0, 0, 0, 0, 8'h41, 0, 1);
      step("run1", 0, 0, 8'h00, 0, 0, 0, 0, 8'h52, 1, 1);
      step("stl1", 0, 0, 8'h00, 0, 1, 0, 0, 8'h63, 2, 1);
      step("stl2", 0, 0, 8'h00, 0, 1, 0, 0, 8'h63, 2, 1);
      step("stl3", 0, 0, 8'h00, 0, 1, 0, 0, 8'h63, 2, 1);
      step("resum",0, 0, 8'h00, 0, 0, 0, 0, 8'h63, 2, 1);
      step("redir",0, 0, 8'h00, 0, 1, 1, 1, 8'h00, 3, 1);
      step("tgt",  0, 0, 8'h00, 0, 0, 0, 0, 8'h52, 1, 1);
      step("run2", 0, 0, 8'h00, 0, 0, 0, 0, 8'h63, 2, 1);
      step("ldrun",1, 4, 8'h99, 1, 0, 0, 0, 8'h74, 3, 1);
      step("noeff",0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 4, 1);
      step("pc5",  0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 5, 1);
      @(negedge clk);
      #2 rst = 0;
      #1;
      chk("arst.code", 32'(instruc_code), 32'h00);
      chk("arst.pc", 32'(pc), 0);
      chk("arst.run", 32'(running), 0);
      @(posedge clk); #1 rst = 1;
      step("ld63", 1, 63, 8'hAA, 0, 0, 0, 0,  8'h00, 0, 0);
      step("ldst", 1, 0,  8'h11, 1, 0, 0, 0,  8'h00, 0, 0);
      step("jmp",  0, 0,  8'h00, 0, 0, 1, 63, 8'h00, 0, 1);
      step("at63", 0, 0,  8'h00, 0, 0, 0, 0,  8'hAA, 63, 1);
      step("wrap", 0, 0,  8'h00, 0, 0, 0, 0,  8'h11, 0, 1);
      step("clr1", 0, 0,  8'h00, 0, 0, 0, 0,  8'h00, 1, 1);
      step("clr2", 0, 0,  8'h00, 0, 0, 0, 0,  8'h00, 2, 1);
      step("clr3", 0, 0,  8'h00, 0, 0, 0, 0,  8'h00, 3, 1);
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      chk("drain", 32'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the 4-stage pipeline. It is the writer side of the IF/ID pipeline register.

- Holds the program counter (PC) and a flop-based 8-bit instruction memory.
- Accepts a program load before execution begins.
- Drives `instruc_code` into IF/ID every cycle.
- Applies stall and redirect (jump/flush) requests coming back from the ID stage.

## Interface
Parameters:
- `PC_W`, 6: PC and memory address width. Memory depth is 2^PC_W = 64 words.
- `NOP_CODE`, 8'h00: code driven when no valid instruction is fetched.

Ports:
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `load_en`, in, 1: write `load_data` to `imem[load_addr]`. Honoured only in IDLE/LOAD.
- `load_addr`, in, PC_W: program load address.
- `load_data`, in, 8: program load word.
- `start`, in, 1: begin execution from address 0.
- `stall`, in, 1: hold PC (ID-stage hazard).
- `redirect`, in, 1: ID stage resolved a jump. Squash the current fetch.
- `redirect_pc`, in, PC_W: jump target.
- `instruc_code`, out, 8: instruction to the IF/ID register.
- `pc`, out, PC_W: current fetch address.
- `running`, out, 1: high in RUN.

## Operation
FSM states: IDLE, LOAD, RUN.
- **Reset (rst=0)**, asynchronous:
  - state=IDLE, pc=0, running=0.
  - All 64 imem words = NOP_CODE.
  - `instruc_code` = NOP_CODE.
- **IDLE:**
  - load_en=1: write the word, go to LOAD.
  - start=1 (with load_en=0): go to RUN.
  - If load_en=1 and start=1 together: the write is performed, next state is RUN.
- **LOAD:**
  - Every cycle with load_en=1 writes `imem[load_addr]`. Later writes to the same address overwrite earlier ones.
  - start=1: go to RUN. A write in the same cycle is still performed.
- **RUN:**
  - Terminal until reset. load_en and start are ignored; imem is read-only.
  - Per-cycle priority: redirect > stall > increment.
    - redirect=1: pc <= redirect_pc, regardless of stall.
    - stall=1 (no redirect): pc held.
    - Otherwise: pc <= pc+1, modulo 2^PC_W (63 -> 0 wraps, no flag).
- **`instruc_code`** is combinational from registered state and `redirect`:
  - NOP_CODE when state≠RUN or redirect=1. This squashes the wrong-path fetch, so a NOP enters IF/ID.
  - imem[pc] otherwise.
- **Stall does not gate the output.** imem[pc] is unchanged, so IF/ID re-latches the same code.
- `pc` is driven at 0 during IDLE/LOAD and is reset to 0 on the IDLE/LOAD -> RUN transition.

## Timing
- **Fetch latency:**
  - Entering RUN at edge N: `instruc_code` = imem[0] during cycle N→N+1, and IF/ID captures it at edge N+1.
  - One instruction per cycle thereafter.
- **Redirect:**
  - Asserted in cycle k: `instruc_code`=NOP in cycle k, and IF/ID captures the NOP at edge k+1.
  - From edge k+1, pc=redirect_pc and the output is imem[redirect_pc]. The branch penalty is exactly 1 bubble.
- **Stall:** held for n cycles, pc stays constant for n edges and resumes incrementing on the first edge with stall=0.
- **Load writes:** visible to reads from the edge after the write. A write and start in the same cycle: the word is readable in the first RUN cycle.
- **Reset mid-RUN:**
  - Output goes to NOP_CODE immediately, with no clock needed.
  - imem is cleared, so the program must be reloaded.

## Structure
- **Package `pipe_pkg`:**
  - PC_W.
  - NOP_CODE.
  - Opcode field constants (instr[7:6]; jump opcode and target field instr[5:0] used by ID).
  - FSM state enum {IDLE, LOAD, RUN}.
- **Sub-module `instr_mem`:** 2^PC_W × 8 flop array with async active-low clear, synchronous write port and asynchronous read port.
- **Top level:** FSM, PC register, output mux.

## Test plan
1. Reset, then read `instruc_code` and pc with no clock edges -> 8'h00 and 0; running=0.
2. Load imem[0..3] = 8'h41, 8'h52, 8'h63, 8'h74, then start -> IF/ID captures 41, 52, 63, 74 on consecutive edges; pc goes 0→1→2→3.
3. In RUN at pc=2, hold stall for 3 cycles -> pc=2 and `instruc_code`=8'h63 for 3 edges, then pc=3.
4. In RUN at pc=3, redirect=1 with redirect_pc=6'd1 while stall=1 -> `instruc_code`=8'h00 in that cycle; next cycle pc=1 and the output is 8'h52.
5. Load imem[63]=8'hAA and imem[0]=8'h11, run with redirect_pc=63 -> output AA, then pc wraps to 0 and the output is 11; load_en pulsed in RUN has no effect on imem.
6. Drop rst mid-RUN at pc=5 -> output 8'h00 and pc=0 asynchronously; after release, state is IDLE and all words read NOP after start.
